// File: rtl/hazard_stall_ctrl_if.sv
// Hazard controller bus: pipeline status into the controller, enables/flushes/counters out.
// master = pipeline side, slave = controller side.
interface hazard_stall_ctrl_if #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 32
);
  logic             branch_i;
  logic             dmem_busy_i;
  logic             DE_MemRead_i;
  logic [REG_W-1:0] DE_Rt_i;
  logic [REG_W-1:0] FD_Rs_i;
  logic [REG_W-1:0] FD_Rt_i;
  logic             FD_UseRs_i;
  logic             FD_UseRt_i;
  logic             cnt_clr_i;
  logic             PCWrite_o;
  logic             FDWrite_o;
  logic             DEWrite_o;
  logic             EMWrite_o;
  logic             MWWrite_o;
  logic             IF_ID_Flush_o;
  logic             ID_EX_Flush_o;
  logic             EX_MEM_Flush_o;
  logic             stalling_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output branch_i, dmem_busy_i, DE_MemRead_i, DE_Rt_i, FD_Rs_i, FD_Rt_i,
           FD_UseRs_i, FD_UseRt_i, cnt_clr_i,
    input  PCWrite_o, FDWrite_o, DEWrite_o, EMWrite_o, MWWrite_o,
           IF_ID_Flush_o, ID_EX_Flush_o, EX_MEM_Flush_o, stalling_o,
           stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  branch_i, dmem_busy_i, DE_MemRead_i, DE_Rt_i, FD_Rs_i, FD_Rt_i,
           FD_UseRs_i, FD_UseRt_i, cnt_clr_i,
    output PCWrite_o, FDWrite_o, DEWrite_o, EMWrite_o, MWWrite_o,
           IF_ID_Flush_o, ID_EX_Flush_o, EX_MEM_Flush_o, stalling_o,
           stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: multi-cycle load-use stall FSM, branch flush,
// data-memory freeze and saturating stall/flush performance counters.
module hazard_stall_ctrl #(
  parameter int unsigned REG_W          = 5,
  parameter int unsigned LOAD_STALL_CYC = 1,
  parameter int unsigned SC_W           = 4,
  parameter int unsigned CNT_W          = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  hazard_stall_ctrl_if.slave bus
);

  typedef enum logic [0:0] {RUN, LSTALL} state_t;

  state_t           state_q, state_d;
  logic [SC_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             stall_inc, flush_inc;
  logic [REG_W-1:0] de_rt;
  logic             hz;

  assign de_rt = bus.DE_Rt_i;
  assign hz    = bus.DE_MemRead_i && (de_rt != '0) &&
                 ((bus.FD_UseRs_i && (de_rt == bus.FD_Rs_i)) ||
                  (bus.FD_UseRt_i && (de_rt == bus.FD_Rt_i)));

  // State and stall down-counter
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= RUN;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Next state and combinational outputs; priority freeze > branch > stall
  always_comb begin
    state_d            = state_q;
    rem_d              = rem_q;
    stall_inc          = 1'b0;
    flush_inc          = 1'b0;
    bus.PCWrite_o      = 1'b1;
    bus.FDWrite_o      = 1'b1;
    bus.DEWrite_o      = 1'b1;
    bus.EMWrite_o      = 1'b1;
    bus.MWWrite_o      = 1'b1;
    bus.IF_ID_Flush_o  = 1'b0;
    bus.ID_EX_Flush_o  = 1'b0;
    bus.EX_MEM_Flush_o = 1'b0;
    if (!rst_i) begin
      state_d = RUN;
      rem_d   = '0;
    end else if (bus.dmem_busy_i) begin
      bus.PCWrite_o = 1'b0;
      bus.FDWrite_o = 1'b0;
      bus.DEWrite_o = 1'b0;
      bus.EMWrite_o = 1'b0;
      bus.MWWrite_o = 1'b0;
    end else if (bus.branch_i) begin
      // Branch is older than the stalled instruction, so it aborts any stall
      bus.FDWrite_o      = 1'b0;
      bus.IF_ID_Flush_o  = 1'b1;
      bus.ID_EX_Flush_o  = 1'b1;
      bus.EX_MEM_Flush_o = 1'b1;
      state_d            = RUN;
      rem_d              = '0;
      flush_inc          = 1'b1;
    end else if (state_q == LSTALL) begin
      bus.PCWrite_o     = 1'b0;
      bus.FDWrite_o     = 1'b0;
      bus.ID_EX_Flush_o = 1'b1;
      stall_inc         = 1'b1;
      if (rem_q == SC_W'(1)) begin
        state_d = RUN;
        rem_d   = '0;
      end else begin
        rem_d = rem_q - SC_W'(1);
      end
    end else if (hz) begin
      bus.PCWrite_o     = 1'b0;
      bus.FDWrite_o     = 1'b0;
      bus.ID_EX_Flush_o = 1'b1;
      stall_inc         = 1'b1;
      if (LOAD_STALL_CYC > 1) begin
        state_d = LSTALL;
        rem_d   = SC_W'(LOAD_STALL_CYC - 1);
      end
    end
  end

  // Saturating performance counters; clear wins over increment
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (bus.cnt_clr_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_inc && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_inc && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign bus.stalling_o  = (state_q == LSTALL);
  assign bus.stall_cnt_o = stall_cnt_q;
  assign bus.flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: three instances cover stall lengths 1 and 3
// and a narrow counter for saturation.
module tb_hazard_stall_ctrl;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  hazard_stall_ctrl_if #(.REG_W(5), .CNT_W(32)) if1 ();
  hazard_stall_ctrl_if #(.REG_W(5), .CNT_W(32)) if3 ();
  hazard_stall_ctrl_if #(.REG_W(5), .CNT_W(4))  ifc ();

  hazard_stall_ctrl #(.REG_W(5), .LOAD_STALL_CYC(1), .SC_W(4), .CNT_W(32))
    u1 (.clk_i(clk), .rst_i(rst_n), .bus(if1.slave));
  hazard_stall_ctrl #(.REG_W(5), .LOAD_STALL_CYC(3), .SC_W(4), .CNT_W(32))
    u3 (.clk_i(clk), .rst_i(rst_n), .bus(if3.slave));
  hazard_stall_ctrl #(.REG_W(5), .LOAD_STALL_CYC(1), .SC_W(4), .CNT_W(4))
    uc (.clk_i(clk), .rst_i(rst_n), .bus(ifc.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic hz3(input logic on);
    if3.DE_MemRead_i = on;
    if3.DE_Rt_i      = on ? 5'd8 : 5'd0;
    if3.FD_Rs_i      = on ? 5'd8 : 5'd0;
    if3.FD_UseRs_i   = on;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    {if1.branch_i, if1.dmem_busy_i, if1.DE_MemRead_i, if1.FD_UseRs_i, if1.FD_UseRt_i, if1.cnt_clr_i} = '0;
    {if1.DE_Rt_i, if1.FD_Rs_i, if1.FD_Rt_i} = '0;
    {if3.branch_i, if3.dmem_busy_i, if3.DE_MemRead_i, if3.FD_UseRs_i, if3.FD_UseRt_i, if3.cnt_clr_i} = '0;
    {if3.DE_Rt_i, if3.FD_Rs_i, if3.FD_Rt_i} = '0;
    {ifc.branch_i, ifc.dmem_busy_i, ifc.DE_MemRead_i, ifc.FD_UseRs_i, ifc.FD_UseRt_i, ifc.cnt_clr_i} = '0;
    {ifc.DE_Rt_i, ifc.FD_Rs_i, ifc.FD_Rt_i} = '0;

    // Reset state
    @(negedge clk); #1;
    chk("rst_pcwrite", 32'(if1.PCWrite_o), 32'd1);
    chk("rst_stalling", 32'(if3.stalling_o), 32'd0);
    chk("rst_stall_cnt", if1.stall_cnt_o, 32'd0);
    chk("rst_flush_cnt", if3.flush_cnt_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single-cycle load-use stall on rs, then on rt
    @(negedge clk);
    if1.DE_MemRead_i = 1'b1; if1.DE_Rt_i = 5'd8; if1.FD_Rs_i = 5'd8; if1.FD_UseRs_i = 1'b1;
    #1;
    chk("t1_pcwrite", 32'(if1.PCWrite_o), 32'd0);
    chk("t1_fdwrite", 32'(if1.FDWrite_o), 32'd0);
    chk("t1_idex_flush", 32'(if1.ID_EX_Flush_o), 32'd1);
    chk("t1_dewrite", 32'(if1.DEWrite_o), 32'd1);
    chk("t1_ifid_flush", 32'(if1.IF_ID_Flush_o), 32'd0);
    chk("t1_stalling", 32'(if1.stalling_o), 32'd0);
    @(negedge clk);
    if1.DE_MemRead_i = 1'b0;
    #1;
    chk("t1_run_pcwrite", 32'(if1.PCWrite_o), 32'd1);
    chk("t1_run_fdwrite", 32'(if1.FDWrite_o), 32'd1);
    chk("t1_stall_cnt", if1.stall_cnt_o, 32'd1);
    @(negedge clk);
    if1.DE_MemRead_i = 1'b1; if1.FD_UseRs_i = 1'b0; if1.FD_Rs_i = 5'd3;
    if1.FD_UseRt_i = 1'b1; if1.FD_Rt_i = 5'd8;
    #1;
    chk("t1_rt_pcwrite", 32'(if1.PCWrite_o), 32'd0);
    @(negedge clk);
    if1.DE_MemRead_i = 1'b0; if1.FD_UseRt_i = 1'b0;
    #1;
    chk("t1_rt_stall_cnt", if1.stall_cnt_o, 32'd2);

    // 2: three-cycle stall, then qualified non-hazards
    @(negedge clk);
    hz3(1'b1);
    #1;
    chk("t2_c1_pcwrite", 32'(if3.PCWrite_o), 32'd0);
    chk("t2_c1_stalling", 32'(if3.stalling_o), 32'd0);
    @(negedge clk);
    hz3(1'b0);
    #1;
    chk("t2_c2_pcwrite", 32'(if3.PCWrite_o), 32'd0);
    chk("t2_c2_stalling", 32'(if3.stalling_o), 32'd1);
    chk("t2_c2_idex_flush", 32'(if3.ID_EX_Flush_o), 32'd1);
    @(negedge clk); #1;
    chk("t2_c3_pcwrite", 32'(if3.PCWrite_o), 32'd0);
    chk("t2_c3_stalling", 32'(if3.stalling_o), 32'd1);
    @(negedge clk); #1;
    chk("t2_end_pcwrite", 32'(if3.PCWrite_o), 32'd1);
    chk("t2_end_stalling", 32'(if3.stalling_o), 32'd0);
    chk("t2_stall_cnt", if3.stall_cnt_o, 32'd3);
    @(negedge clk);
    if3.DE_MemRead_i = 1'b1; if3.DE_Rt_i = 5'd0; if3.FD_Rs_i = 5'd0; if3.FD_UseRs_i = 1'b1;
    #1;
    chk("t2_r0_pcwrite", 32'(if3.PCWrite_o), 32'd1);
    @(negedge clk);
    if3.DE_Rt_i = 5'd8; if3.FD_Rs_i = 5'd8; if3.FD_UseRs_i = 1'b0;
    #1;
    chk("t2_nouse_pcwrite", 32'(if3.PCWrite_o), 32'd1);
    @(negedge clk);
    hz3(1'b0);
    #1;
    chk("t2_nohz_stall_cnt", if3.stall_cnt_o, 32'd3);
    chk("t2_nohz_stalling", 32'(if3.stalling_o), 32'd0);

    // 3: branch on the second stall cycle aborts the stall
    do_reset();
    hz3(1'b1);
    @(negedge clk);
    hz3(1'b0);
    if3.branch_i = 1'b1;
    #1;
    chk("t3_pcwrite", 32'(if3.PCWrite_o), 32'd1);
    chk("t3_fdwrite", 32'(if3.FDWrite_o), 32'd0);
    chk("t3_ifid_flush", 32'(if3.IF_ID_Flush_o), 32'd1);
    chk("t3_idex_flush", 32'(if3.ID_EX_Flush_o), 32'd1);
    chk("t3_exmem_flush", 32'(if3.EX_MEM_Flush_o), 32'd1);
    chk("t3_dewrite", 32'(if3.DEWrite_o), 32'd1);
    @(negedge clk);
    if3.branch_i = 1'b0;
    #1;
    chk("t3_stalling", 32'(if3.stalling_o), 32'd0);
    chk("t3_pcwrite_run", 32'(if3.PCWrite_o), 32'd1);
    chk("t3_flush_cnt", if3.flush_cnt_o, 32'd1);
    chk("t3_stall_cnt", if3.stall_cnt_o, 32'd1);

    // 4: freeze with pending branch mid-stall, then freeze without branch
    do_reset();
    hz3(1'b1);
    @(negedge clk);
    hz3(1'b0);
    if3.dmem_busy_i = 1'b1; if3.branch_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t4_busy_pcwrite", 32'(if3.PCWrite_o), 32'd0);
      chk("t4_busy_mwwrite", 32'(if3.MWWrite_o), 32'd0);
      chk("t4_busy_ifid_flush", 32'(if3.IF_ID_Flush_o), 32'd0);
      chk("t4_busy_idex_flush", 32'(if3.ID_EX_Flush_o), 32'd0);
      chk("t4_busy_stalling", 32'(if3.stalling_o), 32'd1);
      @(negedge clk);
    end
    if3.dmem_busy_i = 1'b0;
    #1;
    chk("t4_flush_exmem", 32'(if3.EX_MEM_Flush_o), 32'd1);
    chk("t4_frozen_stall_cnt", if3.stall_cnt_o, 32'd1);
    @(negedge clk);
    if3.branch_i = 1'b0;
    #1;
    chk("t4_flush_cnt", if3.flush_cnt_o, 32'd1);
    chk("t4_stalling", 32'(if3.stalling_o), 32'd0);
    @(negedge clk);
    hz3(1'b1);
    @(negedge clk);
    hz3(1'b0);
    if3.dmem_busy_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    if3.dmem_busy_i = 1'b0;
    #1;
    chk("t4b_c2_stalling", 32'(if3.stalling_o), 32'd1);
    chk("t4b_c2_stall_cnt", if3.stall_cnt_o, 32'd2);
    @(negedge clk); #1;
    chk("t4b_c3_pcwrite", 32'(if3.PCWrite_o), 32'd0);
    chk("t4b_c3_stalling", 32'(if3.stalling_o), 32'd1);
    @(negedge clk); #1;
    chk("t4b_end_pcwrite", 32'(if3.PCWrite_o), 32'd1);
    chk("t4b_stall_cnt", if3.stall_cnt_o, 32'd4);

    // 5: narrow flush counter saturates; clear beats increment and freeze
    @(negedge clk);
    ifc.branch_i = 1'b1;
    repeat (20) @(negedge clk);
    ifc.branch_i = 1'b0;
    #1;
    chk("t5_saturate", 32'(ifc.flush_cnt_o), 32'd15);
    @(negedge clk);
    ifc.branch_i = 1'b1; ifc.cnt_clr_i = 1'b1;
    @(negedge clk);
    ifc.cnt_clr_i = 1'b0;
    #1;
    chk("t5_clr_with_branch", 32'(ifc.flush_cnt_o), 32'd0);
    repeat (3) @(negedge clk);
    ifc.branch_i = 1'b0;
    #1;
    chk("t5_recount", 32'(ifc.flush_cnt_o), 32'd3);
    @(negedge clk);
    ifc.dmem_busy_i = 1'b1; ifc.cnt_clr_i = 1'b1;
    @(negedge clk);
    ifc.dmem_busy_i = 1'b0; ifc.cnt_clr_i = 1'b0;
    #1;
    chk("t5_clr_in_freeze", 32'(ifc.flush_cnt_o), 32'd0);

    // 6: asynchronous reset mid-stall with hazard inputs still asserted
    @(negedge clk);
    hz3(1'b1);
    @(negedge clk);
    #1;
    chk("t6_pre_stalling", 32'(if3.stalling_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_stalling", 32'(if3.stalling_o), 32'd0);
    chk("t6_pcwrite", 32'(if3.PCWrite_o), 32'd1);
    chk("t6_idex_flush", 32'(if3.ID_EX_Flush_o), 32'd0);
    chk("t6_stall_cnt", if3.stall_cnt_o, 32'd0);
    chk("t6_flush_cnt", if3.flush_cnt_o, 32'd0);
    @(negedge clk);
    hz3(1'b0);
    rst_n = 1'b1;
    #1;
    chk("t6_after_pcwrite", 32'(if3.PCWrite_o), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
